f_sequencer: RTL and testbench
==============================

Name: f_sequencer

Overview:
- Controller that sequences one shared F permutation core (Mix128 absorb followed by G rounds) over a multi-block message.
- Accepts 128-bit blocks over a valid/ready stream. Keeps the 320-bit chaining state between blocks and drives F one block at a time, holding F in reset between runs.
- Returns one RWIDTH word per block on a valid/ready output stream.
- Sits between the host/DMA front end and the F core instance.

Parameters:
- CWIDTH, 320, chaining state width (matches F).
- XWORDS32, 9, number of 32-bit words in the x operand.
- DS_WIDTH, 128, domain-separator width.
- RWIDTH, 32, output word width.
- ROUND_COUNT, 10, width of the rounds field.
- CNT_WIDTH, 16, block counter width.
- TIMEOUT, 1024, maximum cycles allowed in RUN before error.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a message; honoured only in IDLE
- abort  in  1  return to IDLE from any state
- init_c  in  CWIDTH  initial chaining state, latched on start
- init_x  in  XWORDS32*32  x operand, latched on start
- rounds_cfg  in  ROUND_COUNT  rounds value, latched on start
- ds_mid  in  DS_WIDTH  domain separator for non-last blocks
- ds_last  in  DS_WIDTH  domain separator for the last block
- blk_valid  in  1  input block valid
- blk_data  in  128  input block
- blk_last  in  1  marks the final block of the message
- blk_ready  out  1  block accept
- r_valid  out  1  output word valid
- r_data  out  RWIDTH  output word
- r_ready  in  1  output accept
- f_reset  out  1  reset to F; high holds F idle
- f_c  out  CWIDTH  state to F
- f_x  out  XWORDS32*32  x to F
- f_i  out  128  block to F
- f_ds  out  DS_WIDTH  domain separator to F
- f_rounds  out  ROUND_COUNT  rounds to F
- f_cout  in  CWIDTH  F new state
- f_rout  in  RWIDTH  F output word
- f_done  in  1  F completion (level)
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse at message end
- err  out  1  sticky timeout flag
- final_c  out  CWIDTH  chaining state after the last block
- blk_count  out  CNT_WIDTH  blocks completed in the current message

Behaviour:
- Reset values: all registers 0, state IDLE.
  - blk_ready=0, r_valid=0, r_data=0, done=0, err=0, busy=0, blk_count=0, final_c=0.
  - f_reset=1; all f_* data outputs 0.
- f_reset = reset OR (state != RUN), taken from registered state.
- f_c, f_x, f_i, f_ds and f_rounds are driven from registers. They are stable for the whole of RUN.
- States:
  - IDLE: start=1 → latch state_reg=init_c, x_reg=init_x, rounds_reg=rounds_cfg; clear blk_count and err; go WAIT_BLK. start is ignored in every other state.
  - WAIT_BLK:
    - blk_ready=1 (combinational on state).
    - blk_valid=1 → latch i_reg=blk_data and last_reg=blk_last.
    - ds_reg = blk_last ? ds_last : ds_mid.
    - Clear the timeout counter; go RUN.
  - RUN:
    - blk_ready=0; timeout counter increments every cycle.
    - f_done is sampled only here. It is ignored on the first RUN cycle, because F's done may still be settling out of reset.
    - f_done=1 → state_reg=f_cout, r_reg=f_rout, blk_count+1 (saturating at all-ones); go OUT.
    - Counter reaches TIMEOUT-1 without f_done → err=1; go IDLE. No done pulse and no r_valid.
  - OUT:
    - r_valid=1, r_data=r_reg, held stable until r_ready.
    - r_valid & r_ready with last_reg=0 → WAIT_BLK.
    - r_valid & r_ready with last_reg=1 → final_c=state_reg; go FIN.
  - FIN: done=1 for exactly one cycle; go IDLE.
- Latency: block accepted at cycle T → F leaves reset at T+1 → output word valid one cycle after f_done is sampled.
- Output backpressure stalls the sequencer in OUT. F is held in reset during the stall, and no new block is accepted.
- abort=1 in any state → IDLE next cycle.
  - f_reset=1, r_valid=0, blk_ready=0.
  - state_reg, blk_count and err are retained.
  - abort has priority over start, f_done and handshakes in the same cycle.
- reset overrides abort.
- blk_valid with blk_ready=0 is not consumed. r_data only changes on entry to OUT.

Test Plan:
F model used by all scenarios: f_done rises 12 cycles after f_reset falls; f_cout = f_c XOR {f_i, f_i, f_i[63:0]}; f_rout = f_c[31:0] XOR f_i[31:0].
- Single block: init_c=0, blk_data=128'h1, blk_last=1, r_ready=1 → one r_valid, r_data=32'h1, f_ds=ds_last, done pulse, blk_count=1, final_c per the model.
- Three blocks (1, 2, 3), last on the third → three words in order; f_ds=ds_mid for blocks 1-2 and ds_last for block 3; state chains between blocks; done only after word 3; f_reset high between runs.
- Backpressure: r_ready held low 20 cycles → r_valid and r_data stable for the whole stall, blk_ready=0, f_reset=1; transfer completes on the cycle r_ready rises.
- Timeout: TIMEOUT=16 with f_done tied low → err=1 after 16 RUN cycles, state IDLE, no done pulse; err clears on the next start.
- Abort during RUN at cycle 5 → IDLE next cycle, f_reset=1, no r_valid; the following start runs normally.
- Start asserted during WAIT_BLK, and start plus abort in the same cycle → start ignored in both cases; latched init_c unchanged; state IDLE after the abort.

Source files
------------

// File: rtl/f_sequencer_if.sv
// Block-in / word-out stream bundle between the host front end and f_sequencer.
//   blk_valid/blk_data/blk_last/blk_ready : 128-bit message blocks toward the sequencer
//   r_valid/r_data/r_ready                : one RWIDTH result word per block back to the host
// master = host/DMA side, slave = sequencer side.
interface f_sequencer_if #(
  parameter int unsigned RWIDTH = 32
) ();
  localparam int unsigned BWIDTH = 128;

  logic              blk_valid;
  logic [BWIDTH-1:0] blk_data;
  logic              blk_last;
  logic              blk_ready;
  logic              r_valid;
  logic [RWIDTH-1:0] r_data;
  logic              r_ready;

  modport master (
    output blk_valid, blk_data, blk_last, r_ready,
    input  blk_ready, r_valid, r_data
  );

  modport slave (
    input  blk_valid, blk_data, blk_last, r_ready,
    output blk_ready, r_valid, r_data
  );
endinterface

// File: rtl/f_sequencer.sv
// Sequences one shared F permutation core over a multi-block message: keeps the
// chaining state between blocks, runs F once per block (holding it in reset
// otherwise) and returns one result word per block.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start, abort        : begin a message (IDLE only) / return to IDLE from anywhere
//   init_c/init_x/rounds_cfg : per-message configuration, latched on start
//   ds_mid, ds_last     : domain separators for non-last / last blocks
//   bus                 : block input and result output streams (slave side)
//   f_reset, f_c, f_x, f_i, f_ds, f_rounds : drive the F core
//   f_cout, f_rout, f_done                 : F core results
//   busy, done, err, final_c, blk_count    : status
module f_sequencer #(
  parameter int unsigned CWIDTH      = 320,
  parameter int unsigned XWORDS32    = 9,
  parameter int unsigned DS_WIDTH    = 128,
  parameter int unsigned RWIDTH      = 32,
  parameter int unsigned ROUND_COUNT = 10,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [CWIDTH-1:0]        init_c,
  input  logic [XWORDS32*32-1:0]   init_x,
  input  logic [ROUND_COUNT-1:0]   rounds_cfg,
  input  logic [DS_WIDTH-1:0]      ds_mid,
  input  logic [DS_WIDTH-1:0]      ds_last,
  f_sequencer_if.slave             bus,
  output logic                     f_reset,
  output logic [CWIDTH-1:0]        f_c,
  output logic [XWORDS32*32-1:0]   f_x,
  output logic [127:0]             f_i,
  output logic [DS_WIDTH-1:0]      f_ds,
  output logic [ROUND_COUNT-1:0]   f_rounds,
  input  logic [CWIDTH-1:0]        f_cout,
  input  logic [RWIDTH-1:0]        f_rout,
  input  logic                     f_done,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [CWIDTH-1:0]        final_c,
  output logic [CNT_WIDTH-1:0]     blk_count
);

  localparam int unsigned XWIDTH = XWORDS32 * 32;
  localparam int unsigned BWIDTH = 128;
  localparam int unsigned TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_BLK = 3'd1,
    S_RUN      = 3'd2,
    S_OUT      = 3'd3,
    S_FIN      = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [CWIDTH-1:0]      c_q, c_d;
  logic [XWIDTH-1:0]      x_q, x_d;
  logic [ROUND_COUNT-1:0] rounds_q, rounds_d;
  logic [BWIDTH-1:0]      i_q, i_d;
  logic [DS_WIDTH-1:0]    ds_q, ds_d;
  logic                   last_q, last_d;
  logic [RWIDTH-1:0]      r_data_q, r_data_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [CNT_WIDTH-1:0]   blk_count_q, blk_count_d;
  logic                   err_q, err_d;
  logic [CWIDTH-1:0]      final_c_q, final_c_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   blk_ready_q, blk_ready_d;
  logic                   r_valid_q, r_valid_d;

  // Next-state and datapath updates; abort suppresses every update except the return to IDLE.
  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    x_d         = x_q;
    rounds_d    = rounds_q;
    i_d         = i_q;
    ds_d        = ds_q;
    last_d      = last_q;
    r_data_d    = r_data_q;
    tmo_d       = tmo_q;
    blk_count_d = blk_count_q;
    err_d       = err_q;
    final_c_d   = final_c_q;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            c_d         = init_c;
            x_d         = init_x;
            rounds_d    = rounds_cfg;
            blk_count_d = '0;
            err_d       = 1'b0;
            state_d     = S_WAIT_BLK;
          end
        end
        S_WAIT_BLK: begin
          if (bus.blk_valid) begin
            i_d     = bus.blk_data;
            last_d  = bus.blk_last;
            ds_d    = bus.blk_last ? ds_last : ds_mid;
            tmo_d   = '0;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          tmo_d = tmo_q + TW'(1);
          // tmo_q == 0 marks the first RUN cycle, where F's done may still be stale.
          if ((tmo_q != '0) && f_done) begin
            c_d      = f_cout;
            r_data_d = f_rout;
            if (blk_count_q != '1) begin
              blk_count_d = blk_count_q + CNT_WIDTH'(1);
            end
            state_d = S_OUT;
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_OUT: begin
          if (bus.r_ready) begin
            if (last_q) begin
              final_c_d = c_q;
              state_d   = S_FIN;
            end else begin
              state_d = S_WAIT_BLK;
            end
          end
        end
        S_FIN: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Status outputs are registered decodes of the next state.
    done_d      = (state_d == S_FIN);
    busy_d      = (state_d != S_IDLE);
    blk_ready_d = (state_d == S_WAIT_BLK);
    r_valid_d   = (state_d == S_OUT);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      c_q         <= '0;
      x_q         <= '0;
      rounds_q    <= '0;
      i_q         <= '0;
      ds_q        <= '0;
      last_q      <= 1'b0;
      r_data_q    <= '0;
      tmo_q       <= '0;
      blk_count_q <= '0;
      err_q       <= 1'b0;
      final_c_q   <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      blk_ready_q <= 1'b0;
      r_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      x_q         <= x_d;
      rounds_q    <= rounds_d;
      i_q         <= i_d;
      ds_q        <= ds_d;
      last_q      <= last_d;
      r_data_q    <= r_data_d;
      tmo_q       <= tmo_d;
      blk_count_q <= blk_count_d;
      err_q       <= err_d;
      final_c_q   <= final_c_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      blk_ready_q <= blk_ready_d;
      r_valid_q   <= r_valid_d;
    end
  end

  // F runs only while in RUN; reset forces it idle immediately.
  assign f_reset   = reset | (state_q != S_RUN);
  assign f_c       = c_q;
  assign f_x       = x_q;
  assign f_i       = i_q;
  assign f_ds      = ds_q;
  assign f_rounds  = rounds_q;

  assign bus.blk_ready = blk_ready_q;
  assign bus.r_valid   = r_valid_q;
  assign bus.r_data    = r_data_q;

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign final_c   = final_c_q;
  assign blk_count = blk_count_q;

endmodule

// File: tb/tb_f_sequencer.sv
// Directed bench for f_sequencer with a behavioural F core and a result-word scoreboard.
module tb_f_sequencer;
  localparam int unsigned CW = 320;
  localparam int unsigned XW = 288;

  logic            clk = 1'b0;
  logic            reset;
  logic            start, abort;
  logic [CW-1:0]   init_c;
  logic [XW-1:0]   init_x;
  logic [9:0]      rounds_cfg;
  logic [127:0]    ds_mid, ds_last;
  logic            f_reset;
  logic [CW-1:0]   f_c, f_cout, final_c;
  logic [XW-1:0]   f_x;
  logic [127:0]    f_i, f_ds;
  logic [9:0]      f_rounds;
  logic [31:0]     f_rout;
  logic            f_done;
  logic            busy, done, err;
  logic [15:0]     blk_count;

  f_sequencer_if #(.RWIDTH(32)) bus ();

  f_sequencer #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .init_c(init_c), .init_x(init_x), .rounds_cfg(rounds_cfg),
    .ds_mid(ds_mid), .ds_last(ds_last), .bus(bus),
    .f_reset(f_reset), .f_c(f_c), .f_x(f_x), .f_i(f_i), .f_ds(f_ds),
    .f_rounds(f_rounds), .f_cout(f_cout), .f_rout(f_rout), .f_done(f_done),
    .busy(busy), .done(done), .err(err), .final_c(final_c), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  // Behavioural F: done 12 cycles after leaving reset, simple XOR mixing.
  logic [4:0] fcnt;
  logic       f_en;
  always @(posedge clk) begin
    if (f_reset) fcnt <= 5'd0;
    else if (fcnt != 5'd31) fcnt <= fcnt + 5'd1;
  end
  assign f_done = f_en && (fcnt >= 5'd12);
  assign f_cout = f_c ^ {f_i, f_i, f_i[63:0]};
  assign f_rout = f_c[31:0] ^ f_i[31:0];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int words = 0;
  logic [31:0]   exp_q[$];
  logic [CW-1:0] model_c;
  logic [XW-1:0] exp_x;
  logic [9:0]    exp_rounds;
  logic          stall_q = 1'b0;
  logic [31:0]   stall_data;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Result monitor: scoreboard pop on each transfer, stability during stalls, done cycles.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (stall_q) begin
        chk("stall_r_valid", bus.r_valid, 1);
        chk("stall_r_data", bus.r_data, stall_data);
        chk("stall_blk_ready", bus.blk_ready, 0);
        chk("stall_f_reset", f_reset, 1);
      end
      if (bus.r_valid === 1'b1 && bus.r_ready === 1'b1) begin
        words++;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_word observed=%0h expected=none", bus.r_data);
        end
        if (exp_q.size() != 0) chk("r_data", bus.r_data, exp_q.pop_front());
      end
      stall_q    = (bus.r_valid === 1'b1) && (bus.r_ready === 1'b0);
      stall_data = bus.r_data;
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic do_start();
    pulse_start();
    model_c    = init_c;
    exp_x      = init_x;
    exp_rounds = rounds_cfg;
  endtask

  // Offers one block, waits for acceptance, checks F inputs on the first RUN cycle.
  task automatic send_block(input logic [127:0] d, input logic last, input bit expect_word);
    int n = 0;
    @(posedge clk); #1;
    bus.blk_valid = 1'b1;
    bus.blk_data  = d;
    bus.blk_last  = last;
    step();
    while (bus.blk_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("blk_ready_seen", bus.blk_ready, 1);
    chk("f_reset_between_runs", f_reset, 1);
    @(posedge clk); #1 bus.blk_valid = 1'b0;
    step();
    chk("f_reset_run", f_reset, 0);
    chk("f_c", f_c, model_c);
    chk("f_i", f_i, d);
    chk("f_ds", f_ds, last ? ds_last : ds_mid);
    chk("f_x", f_x, exp_x);
    chk("f_rounds", f_rounds, exp_rounds);
    if (expect_word) begin
      exp_q.push_back(model_c[31:0] ^ d[31:0]);
      model_c = model_c ^ {d, d, d[63:0]};
    end
  endtask

  task automatic wait_done();
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < 300) begin
      step();
      n++;
    end
    step();
    step();
    chk("done_pulses", done_cnt - d0, 1);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int runs;
    int n;
    int d0;
    int w0;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    init_c = '0; init_x = '0; rounds_cfg = '0;
    ds_mid  = 128'hD0D0_0000_1111_2222_3333_4444_5555_6666;
    ds_last = 128'hE1E1_9999_8888_7777_6666_5555_4444_3333;
    bus.blk_valid = 1'b0; bus.blk_data = '0; bus.blk_last = 1'b0; bus.r_ready = 1'b1;
    f_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    step();

    // Reset state
    chk("rst_blk_ready", bus.blk_ready, 0);
    chk("rst_r_valid", bus.r_valid, 0);
    chk("rst_r_data", bus.r_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_blk_count", blk_count, 0);
    chk("rst_final_c", final_c, 0);
    chk("rst_f_reset", f_reset, 1);
    chk("rst_f_c", f_c, 0);

    // Single block
    init_c = '0; init_x = {9{32'h0BAD_F00D}}; rounds_cfg = 10'd12;
    do_start();
    send_block(128'h1, 1'b1, 1'b1);
    wait_done();
    chk("single_blk_count", blk_count, 1);
    chk("single_final_c", final_c, model_c);

    // Three chained blocks
    init_c = {10{32'h1357_9BDF}}; init_x = {9{32'h2468_ACE0}}; rounds_cfg = 10'd7;
    w0 = words;
    do_start();
    send_block(128'h1, 1'b0, 1'b1);
    d0 = done_cnt;
    send_block(128'h2, 1'b0, 1'b1);
    chk("no_early_done", done_cnt, d0);
    send_block(128'h3, 1'b1, 1'b1);
    wait_done();
    chk("three_words", words - w0, 3);
    chk("three_blk_count", blk_count, 3);
    chk("three_final_c", final_c, model_c);

    // Output backpressure
    init_c = {10{32'hF0E1_D2C3}};
    @(posedge clk); #1 bus.r_ready = 1'b0;
    do_start();
    send_block(128'h0000_CAFE_0000_1111_2222_3333_4444_5555, 1'b1, 1'b1);
    n = 0;
    while (bus.r_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("bp_r_valid_seen", bus.r_valid, 1);
    repeat (20) @(posedge clk);
    #1 bus.r_ready = 1'b1;
    step();
    step();
    chk("bp_r_valid_dropped", bus.r_valid, 0);
    chk("bp_done_after", done, 1);
    step();
    chk("bp_final_c", final_c, model_c);

    // Timeout with F never finishing
    f_en = 1'b0;
    d0 = done_cnt;
    w0 = words;
    do_start();
    send_block(128'h77, 1'b1, 1'b0);
    runs = 1;
    step();
    while (f_reset === 1'b0 && runs < 100) begin
      runs++;
      step();
    end
    chk("tmo_run_cycles", runs, 16);
    chk("tmo_err", err, 1);
    chk("tmo_busy", busy, 0);
    step();
    chk("tmo_no_done", done_cnt, d0);
    chk("tmo_no_word", words, w0);
    f_en = 1'b1;

    // Abort on the fifth RUN cycle
    init_c = {10{32'h0F0F_3C3C}};
    do_start();
    step();
    chk("start_clears_err", err, 0);
    chk("start_busy", busy, 1);
    w0 = words;
    send_block(128'h55, 1'b1, 1'b0);
    repeat (3) step();
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    step();
    chk("abort_f_reset", f_reset, 1);
    chk("abort_r_valid", bus.r_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_blk_ready", bus.blk_ready, 0);
    repeat (15) step();
    chk("abort_no_word", words, w0);
    init_c = {10{32'h8421_1248}};
    do_start();
    send_block(128'h9, 1'b1, 1'b1);
    wait_done();
    chk("post_abort_blk_count", blk_count, 1);

    // start ignored in WAIT_BLK, and start+abort in IDLE
    init_c = {10{32'hAAAA_5555}};
    do_start();
    step();
    init_c = {10{32'h1111_EEEE}};
    pulse_start();
    step();
    chk("wait_start_blk_ready", bus.blk_ready, 1);
    chk("wait_start_busy", busy, 1);
    send_block(128'h42, 1'b1, 1'b1);
    wait_done();
    chk("wait_start_final_c", final_c, model_c);
    init_c = {10{32'h2222_DDDD}};
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    step();
    chk("start_abort_busy", busy, 0);
    chk("start_abort_blk_ready", bus.blk_ready, 0);
    step();
    chk("start_abort_busy2", busy, 0);

    repeat (5) step();
    chk("sb_empty", exp_q.size(), 0);
    chk("total_words", words, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
